// File: rtl/spi_host_if.sv
// Byte-source handshake and frame status shared by a command source and spi_host.
// The source drives cmd_data/cmd_valid and waits on cmd_ready; the host reports
// busy for the whole frame and pulses tx_done when chip select releases.
interface spi_host_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       tx_done;

  // Command source side.
  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready,
    input  busy,
    input  tx_done
  );

  // spi_host side.
  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready,
    output busy,
    output tx_done
  );
endinterface

// File: rtl/spi_host.sv
// Write-only SPI host: serializes one command byte per frame, mode 0, MSB first,
// active-low chip select. Every SPI pin comes straight from a flop; the only
// combinational output is cmd_ready.
module spi_host #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned CS_GAP      = 4
) (
  input  logic       clk,
  input  logic       rst,
  spi_host_if.slave  cmd,
  output logic       spi_clk,
  output logic       mosi,
  output logic       cs
);

  // Half-period counter only ever needs to reach HALF_PERIOD-1.
  localparam int unsigned HpW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  // Setup, hold and gap never overlap, so one phase counter serves all three;
  // it is sized for whichever of them is longest.
  localparam int unsigned CntMaxSh = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CntMax   = (CntMaxSh > CS_GAP) ? CntMaxSh : CS_GAP;
  localparam int unsigned CntW     = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [HpW-1:0]  HpLast    = HpW'(HALF_PERIOD - 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  state_e          state_q;
  // Bit 7 goes straight to mosi at acceptance, so only bits 6:0 are kept.
  logic [6:0]      shreg_q;
  logic [2:0]      bit_cnt_q;
  logic [HpW-1:0]  hp_cnt_q;
  logic [CntW-1:0] ph_cnt_q;
  logic            spi_clk_q;
  logic            mosi_q;
  logic            cs_q;
  logic            busy_q;
  logic            tx_done_q;

  // Ready only in IDLE and never while reset is asserted.
  assign cmd.cmd_ready = (state_q == StIdle) && !rst;
  assign cmd.busy      = busy_q;
  assign cmd.tx_done   = tx_done_q;
  assign spi_clk       = spi_clk_q;
  assign mosi          = mosi_q;
  assign cs            = cs_q;

  // Frame sequencer: state, counters and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= 3'd0;
      hp_cnt_q  <= '0;
      ph_cnt_q  <= '0;
      spi_clk_q <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // cmd_ready is implied here: state is IDLE and rst is low.
          if (cmd.cmd_valid) begin
            shreg_q  <= cmd.cmd_data[6:0];
            mosi_q   <= cmd.cmd_data[7];
            cs_q     <= 1'b0;
            busy_q   <= 1'b1;
            ph_cnt_q <= '0;
            state_q  <= StSetup;
          end
        end

        StSetup: begin
          if (ph_cnt_q == SetupLast) begin
            ph_cnt_q <= '0;
            hp_cnt_q <= '0;
            state_q  <= StShift;
          end else begin
            ph_cnt_q <= ph_cnt_q + CntW'(1);
          end
        end

        StShift: begin
          if (hp_cnt_q == HpLast) begin
            hp_cnt_q <= '0;
            if (!spi_clk_q) begin
              spi_clk_q <= 1'b1;
            end else begin
              spi_clk_q <= 1'b0;
              if (bit_cnt_q == 3'd7) begin
                // Last high phase done: mosi keeps bit 0 through HOLD.
                bit_cnt_q <= 3'd0;
                ph_cnt_q  <= '0;
                state_q   <= StHold;
              end else begin
                // Next bit launches on the falling edge, stable for the next rise.
                bit_cnt_q <= bit_cnt_q + 3'd1;
                mosi_q    <= shreg_q[6];
                shreg_q   <= {shreg_q[5:0], 1'b0};
              end
            end
          end else begin
            hp_cnt_q <= hp_cnt_q + HpW'(1);
          end
        end

        StHold: begin
          if (ph_cnt_q == HoldLast) begin
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            tx_done_q <= 1'b1;
            ph_cnt_q  <= '0;
            state_q   <= StGap;
          end else begin
            ph_cnt_q <= ph_cnt_q + CntW'(1);
          end
        end

        StGap: begin
          if (ph_cnt_q == GapLast) begin
            busy_q   <= 1'b0;
            ph_cnt_q <= '0;
            state_q  <= StIdle;
          end else begin
            ph_cnt_q <= ph_cnt_q + CntW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host: a default-parameter instance (A) and a minimum-timing
// instance (B). Accepted bytes go into a scoreboard queue; a per-instance
// monitor decodes each frame off the SPI pins and checks bits and cycle timing.
module tb_spi_host;

  localparam int HA = 4, SA = 2, OA = 2, GA = 4;
  localparam int HB = 1, SB = 1, OB = 1, GB = 1;
  localparam int FA = 1 + SA + 16 * HA + OA;  // cs rise / tx_done, rel. to handshake
  localparam int PA = FA + GA;                // frame period
  localparam int FB = 1 + SB + 16 * HB + OB;
  localparam int PB = FB + GB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_host_if ifa ();
  spi_host_if ifb ();
  logic sck_a, mosi_a, cs_a;
  logic sck_b, mosi_b, cs_b;

  spi_host #(
    .HALF_PERIOD(HA), .CS_SETUP(SA), .CS_HOLD(OA), .CS_GAP(GA)
  ) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .cmd     (ifa),
    .spi_clk (sck_a),
    .mosi    (mosi_a),
    .cs      (cs_a)
  );

  spi_host #(
    .HALF_PERIOD(HB), .CS_SETUP(SB), .CS_HOLD(OB), .CS_GAP(GB)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .cmd     (ifb),
    .spi_clk (sck_b),
    .mosi    (mosi_b),
    .cs      (cs_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         hs;
  } exp_t;
  exp_t sbq[$];

  // Monitor state, indexed by instance (0 = A, 1 = B).
  logic       p_cs[2]   = '{1'b1, 1'b1};
  logic       p_sck[2]  = '{1'b0, 1'b0};
  logic       p_busy[2] = '{1'b0, 1'b0};
  int         nb[2];
  logic [7:0] rx[2];
  logic [7:0] ex[2];
  int         rise_c[2];
  int         hs_c[2];
  int         frames[2] = '{0, 0};
  bit         mon_en = 1'b1;

  task automatic mon(input int id, input logic c, input logic sk, input logic mo,
                     input logic td, input logic bsy);
    int h, s, f, p, idx;
    h = (id == 0) ? HA : HB;
    s = (id == 0) ? SA : SB;
    f = (id == 0) ? FA : FB;
    p = (id == 0) ? PA : PB;
    if (mon_en) begin
      if (p_cs[id] && !c) begin
        if (sbq.size() == 0) begin
          chk("frame_without_cmd", 1, 0);
        end else begin
          hs_c[id] = sbq[0].hs;
          ex[id]   = sbq[0].data;
        end
        nb[id] = 0;
        rx[id] = 8'h00;
        chk("cs_fall_cycle", cyc - hs_c[id], 1);
        chk("mosi_first_bit", int'(mo), int'(ex[id][7]));
      end
      if (!c && !p_sck[id] && sk) begin
        chk("sck_rise_cycle", cyc - hs_c[id], 1 + s + h + 2 * h * nb[id]);
        rx[id]     = {rx[id][6:0], mo};
        nb[id]     = nb[id] + 1;
        rise_c[id] = cyc;
      end
      if (!c && p_sck[id] && !sk) begin
        chk("sck_fall_cycle", cyc - rise_c[id], h);
        idx = (nb[id] < 8) ? 7 - nb[id] : 0;
        chk("mosi_after_fall", int'(mo), int'(ex[id][idx]));
      end
      if (!p_cs[id] && c) begin
        chk("bits_in_frame", nb[id], 8);
        chk("rx_byte", int'(rx[id]), int'(ex[id]));
        chk("cs_rise_cycle", cyc - hs_c[id], f);
        chk("tx_done_at_cs_rise", int'(td), 1);
        chk("mosi_idle", int'(mo), 0);
        if (sbq.size() > 0) void'(sbq.pop_front());
        frames[id] = frames[id] + 1;
      end else if (td) begin
        chk("tx_done_stray", int'(td), 0);
      end
      if (p_busy[id] && !bsy) chk("busy_fall_cycle", cyc - hs_c[id], p);
    end
    p_cs[id]   = c;
    p_sck[id]  = sk;
    p_busy[id] = bsy;
  endtask

  always @(negedge clk) mon(0, cs_a, sck_a, mosi_a, ifa.tx_done, ifa.busy);
  always @(negedge clk) mon(1, cs_b, sck_b, mosi_b, ifb.tx_done, ifb.busy);

  // Offer a byte from the next cycle on, wait (bounded) for the handshake and
  // log it to the scoreboard. Returns #1 after the accepting edge.
  task automatic send(input int id, input logic [7:0] d, input bit keep, output int hs);
    exp_t e;
    @(posedge clk);
    #1;
    if (id == 0) begin ifa.cmd_valid = 1'b1; ifa.cmd_data = d; end
    else begin ifb.cmd_valid = 1'b1; ifb.cmd_data = d; end
    hs = -1;
    for (int i = 0; i < 200 && hs < 0; i++) begin
      @(negedge clk);
      if ((id == 0) ? ifa.cmd_ready : ifb.cmd_ready) begin
        hs     = cyc;
        e.data = d;
        e.hs   = cyc;
        sbq.push_back(e);
      end
    end
    if (hs < 0) chk("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (id == 0) begin ifa.cmd_valid = 1'b0; ifa.cmd_data = ~d; end
      else begin ifb.cmd_valid = 1'b0; ifb.cmd_data = ~d; end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         keep;  // hold cmd_valid high into the next row
    int         idle;  // cycles to wait before offering this byte
  } vec_t;

  initial begin
    vec_t vt[6];
    int   hs, prev_hs, txd;

    ifa.cmd_valid = 1'b0; ifa.cmd_data = 8'h00;
    ifb.cmd_valid = 1'b0; ifb.cmd_data = 8'h00;

    vt[0] = '{8'hA5, 1'b0, 0};
    vt[1] = '{8'h30, 1'b1, 0};
    vt[2] = '{8'hF0, 1'b0, 0};
    vt[3] = '{8'h20, 1'b0, 100};
    vt[4] = '{8'h5A, 1'b0, 0};
    vt[5] = '{8'hC3, 1'b0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_low_in_reset", int'(ifa.cmd_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cs_a", int'(cs_a), 1);
    chk("rst_sck_a", int'(sck_a), 0);
    chk("rst_mosi_a", int'(mosi_a), 0);
    chk("rst_busy_a", int'(ifa.busy), 0);
    chk("rst_tx_done_a", int'(ifa.tx_done), 0);
    chk("rst_ready_a", int'(ifa.cmd_ready), 1);
    chk("rst_cs_b", int'(cs_b), 1);
    chk("rst_ready_b", int'(ifb.cmd_ready), 1);

    // Table of frames on A; data is scrambled mid-SHIFT on released rows.
    prev_hs = 0;
    for (int i = 0; i < 6; i++) begin
      repeat (vt[i].idle) @(posedge clk);
      send(0, vt[i].data, vt[i].keep, hs);
      if (i > 0 && vt[i].idle == 0) chk("handshake_period", hs - prev_hs, PA);
      prev_hs = hs;
      if (!vt[i].keep) begin
        repeat (12) @(posedge clk);
        #1 ifa.cmd_data = 8'($urandom);
      end
    end
    for (int i = 0; i < 500 && sbq.size() > 0; i++) @(posedge clk);
    chk("queue_drained_a", sbq.size(), 0);
    repeat (GA + 4) @(posedge clk);

    // Reset at cycle 30 of a frame
    send(0, 8'h96, 1'b0, hs);
    repeat (29) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    chk("mid_frame_cs_low", int'(cs_a), 0);
    chk("ready_low_during_rst", int'(ifa.cmd_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_cs", int'(cs_a), 1);
    chk("abort_sck", int'(sck_a), 0);
    chk("abort_mosi", int'(mosi_a), 0);
    chk("abort_busy", int'(ifa.busy), 0);
    chk("abort_tx_done", int'(ifa.tx_done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(ifa.cmd_ready), 1);
    txd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifa.tx_done) txd++;
    end
    chk("no_tx_done_after_abort", txd, 0);
    sbq.delete();
    mon_en = 1'b1;

    // Minimum-timing instance: 0xFF then 0x00
    send(1, 8'hFF, 1'b0, hs);
    prev_hs = hs;
    send(1, 8'h00, 1'b0, hs);
    chk("handshake_period_b", hs - prev_hs, PB);
    for (int i = 0; i < 200 && sbq.size() > 0; i++) @(posedge clk);
    chk("queue_drained_b", sbq.size(), 0);
    repeat (GB + 4) @(posedge clk);

    chk("frames_a", frames[0], 6);
    chk("frames_b", frames[1], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
